ifid_hazard: RTL and testbench
==============================

IFID_HAZARD -- requirements
Module: ifid_hazard

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0000, instruction word loaded on bubble or flush.
REQ-002 Parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst, with rst=0 meaning reset asserted.
REQ-004 clk  input  1  rising-edge clock shared with the fetch stage.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 Order  input  32  instruction word fetched this cycle.
REQ-007 FAOut  input  32  PC+4 of the fetched instruction.
REQ-008 Flag  input  1  branch taken in EX; redirect this cycle.
REQ-009 Jump  input  1  jump resolved; redirect this cycle.
REQ-010 ex_memread  input  1  the instruction in ID/EX is a load.
REQ-011 ex_rd  input  5  destination register of the ID/EX instruction.
REQ-012 Hazard  output  1  stall request to fetch; fetch holds its PC while Hazard=1.
REQ-013 id_inst  output  32  registered instruction presented to decode.
REQ-014 id_pc4  output  32  registered PC+4 presented to decode.
REQ-015 id_valid  output  1  id_inst holds a real instruction.
REQ-016 ex_bubble  output  1  ID/EX shall load a bubble this cycle.
REQ-017 stall_cnt, flush_cnt  output  CNT_W  saturating event counters.

Function
REQ-018 FSM states SHALL be RUN, STALL and FLUSH, held in a registered state variable.
REQ-019 Source fields SHALL be RS=id_inst[25:21] and RT=id_inst[20:16].
REQ-020 A load-use condition exists when id_valid=1, ex_memread=1, ex_rd!=0, and ex_rd equals RS or RT.
REQ-021 Hazard SHALL be combinational and equal to (load-use condition AND NOT (Flag OR Jump)), so fetch sees it in the same cycle.
REQ-022 ex_bubble SHALL equal Hazard OR NOT id_valid.
REQ-023 Redirect (Flag OR Jump) at a rising edge:
- id_inst<=NOP_INST, id_valid<=0, id_pc4<=FAOut.
- state<=FLUSH.
- flush_cnt increments.
- Redirect has priority over stall.
REQ-024 Hazard=1 at a rising edge, no redirect:
- id_inst, id_pc4 and id_valid hold their values.
- state<=STALL.
- stall_cnt increments.
REQ-025 Neither redirect nor Hazard at a rising edge:
- id_inst<=Order, id_pc4<=FAOut, id_valid<=1.
- state<=RUN.
REQ-026 STALL SHALL last one cycle in normal operation, because the inserted bubble clears ex_memread. A repeated load-use condition SHALL re-stall and increment stall_cnt again.
REQ-027 FLUSH SHALL last exactly one cycle. A new redirect while in FLUSH SHALL remain in FLUSH and increment flush_cnt.
REQ-028 Counters SHALL saturate at all-ones and never wrap.
REQ-029 ex_rd=0 SHALL never cause a stall.

Reset
REQ-030 While rst=0, asynchronously:
- state=FLUSH, id_inst=NOP_INST, id_pc4=0, id_valid=0.
- stall_cnt=0, flush_cnt=0.
- Hazard=0 and ex_bubble=1, following from id_valid=0.
REQ-031 On the first rising edge after rst rises, the module SHALL capture Order and FAOut as in REQ-025.
REQ-032 Reset asserted mid-stall or mid-flush SHALL discard that state immediately.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the RS/RT field bit positions, and the default NOP constant.
REQ-034 The two counters SHALL share one sub-module, sat_counter (ports: clk, rst, inc, count).

Verification
REQ-035 A bench SHALL cover at least these directed scenarios:
- Reset: release rst; Order=32'h1234_5678, FAOut=4 -> next edge id_inst=32'h1234_5678, id_pc4=4, id_valid=1.
- Load-use: id_inst RS=5, ex_memread=1, ex_rd=5 -> Hazard=1 and ex_bubble=1 the same cycle; id_inst held one edge; stall_cnt=1.
- Zero register: ex_rd=0 matching RT=0 with ex_memread=1 -> Hazard=0, no stall.
- Simultaneous events: load-use condition plus Flag=1 -> Hazard=0; next edge id_valid=0, id_inst=NOP_INST; flush_cnt=1.
- Back-to-back redirects: Jump=1 for 3 edges -> state stays FLUSH; flush_cnt=3; id_valid=0 throughout.
- Saturation: CNT_W=2 with 5 stalls -> stall_cnt=3; reset pulse mid-stall -> counters read 0 immediately.

Source files
------------

// File: rtl/ifid_hazard_pkg.sv
// Shared types and constants for the IF/ID pipeline register and its
// load-use / redirect hazard control.
package ifid_hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ifid_state_e;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifid_hazard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ifid_hazard.sv
// IF/ID pipeline register with load-use stall detection and branch/jump
// flush; the stall request is combinational so fetch can hold its PC this cycle.
module ifid_hazard
  import ifid_hazard_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Order,
  input  logic [31:0]      FAOut,
  input  logic             Flag,
  input  logic             Jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  output logic             Hazard,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ifid_state_e state, next_state;
  logic        redirect;
  logic        load_use;
  logic [4:0]  rs;
  logic [4:0]  rt;

  assign rs       = id_inst[RS_HI:RS_LO];
  assign rt       = id_inst[RT_HI:RT_LO];
  assign redirect = Flag | Jump;
  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = id_valid && ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == rs) || (ex_rd == rt));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FLUSH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = RUN;
    Hazard     = load_use && !redirect;
    ex_bubble  = Hazard || !id_valid;
    case (state)
      RUN, STALL, FLUSH: begin
        if (redirect) begin
          next_state = FLUSH;
        end else if (Hazard) begin
          next_state = STALL;
        end else begin
          next_state = RUN;
        end
      end
      default: next_state = FLUSH;
    endcase
  end

  // A redirect squashes the wrong-path fetch even if a stall was pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_inst  <= NOP_INST;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (redirect) begin
      id_inst  <= NOP_INST;
      id_pc4   <= FAOut;
      id_valid <= 1'b0;
    end else if (!Hazard) begin
      id_inst  <= Order;
      id_pc4   <= FAOut;
      id_valid <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (Hazard),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_ifid_hazard.sv
// Table-driven scoreboard bench for ifid_hazard, with a second CNT_W=2 copy
// sharing the same stimulus to observe counter saturation.
module tb_ifid_hazard;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] I0  = 32'h1234_5678;  // RS=17 RT=20
  localparam logic [31:0] IA  = 32'h00A0_0000;  // RS=5  RT=0
  localparam logic [31:0] IB  = 32'h0000_1111;  // RS=0  RT=0
  localparam logic [31:0] IC  = 32'h0062_0000;  // RS=3  RT=2
  localparam logic [31:0] ID  = 32'h2222_0000;  // RS=17 RT=2
  localparam logic [31:0] IE  = 32'hDEAD_BEEF;  // RS=21 RT=13

  typedef struct packed {
    logic [31:0] order;
    logic [31:0] faout;
    logic        flag;
    logic        jump;
    logic        memread;
    logic [4:0]  ex_rd;
    logic        hazard;
    logic        bubble;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] stall;
    logic [15:0] flush;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] Order;
  logic [31:0] FAOut;
  logic        Flag;
  logic        Jump;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        Hazard;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        ex_bubble;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic        s_hazard;
  logic [31:0] s_inst;
  logic [31:0] s_pc4;
  logic        s_valid;
  logic        s_bubble;
  logic [1:0]  s_stall;
  logic [1:0]  s_flush;

  int   checks;
  int   failures;
  exp_t exp_q[$];
  vec_t vecs[16];
  vec_t hand[5];

  ifid_hazard dut (
    .clk(clk), .rst(rst), .Order(Order), .FAOut(FAOut), .Flag(Flag), .Jump(Jump),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .Hazard(Hazard), .id_inst(id_inst),
    .id_pc4(id_pc4), .id_valid(id_valid), .ex_bubble(ex_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ifid_hazard #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .Order(Order), .FAOut(FAOut), .Flag(Flag), .Jump(Jump),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .Hazard(s_hazard), .id_inst(s_inst),
    .id_pc4(s_pc4), .id_valid(s_valid), .ex_bubble(s_bubble),
    .stall_cnt(s_stall), .flush_cnt(s_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] order, input logic [31:0] faout,
                              input logic flag, input logic jump, input logic memread,
                              input logic [4:0] rd, input logic hz, input logic bb,
                              input logic [31:0] inst, input logic [31:0] pc4,
                              input logic valid, input logic [15:0] st, input logic [15:0] fl);
    vec_t v;
    v.order = order; v.faout = faout; v.flag = flag; v.jump = jump;
    v.memread = memread; v.ex_rd = rd; v.hazard = hz; v.bubble = bb;
    v.inst = inst; v.pc4 = pc4; v.valid = valid; v.stall = st; v.flush = fl;
    return v;
  endfunction

  function automatic logic [31:0] sat3(input logic [15:0] x);
    return (x > 16'd3) ? 32'd3 : {16'd0, x};
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    Order = v.order; FAOut = v.faout; Flag = v.flag; Jump = v.jump;
    ex_memread = v.memread; ex_rd = v.ex_rd;
    e.inst = v.inst; e.pc4 = v.pc4; e.valid = v.valid; e.stall = v.stall; e.flush = v.flush;
    exp_q.push_back(e);
    #1;
    checkValue({tag, " Hazard"}, {31'd0, Hazard}, {31'd0, v.hazard});
    checkValue({tag, " ex_bubble"}, {31'd0, ex_bubble}, {31'd0, v.bubble});
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      checkValue({tag, " id_inst"}, id_inst, e.inst);
      checkValue({tag, " id_pc4"}, id_pc4, e.pc4);
      checkValue({tag, " id_valid"}, {31'd0, id_valid}, {31'd0, e.valid});
      checkValue({tag, " stall_cnt"}, {16'd0, stall_cnt}, {16'd0, e.stall});
      checkValue({tag, " flush_cnt"}, {16'd0, flush_cnt}, {16'd0, e.flush});
      checkValue({tag, " sat stall_cnt"}, {30'd0, s_stall}, sat3(e.stall));
      checkValue({tag, " sat flush_cnt"}, {30'd0, s_flush}, sat3(e.flush));
    end
  endtask

  // Asserts reset between clock edges, checks it takes effect without an edge,
  // holds it across one edge, then releases before the next stimulus.
  task automatic resetPulse(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkValue({tag, " rst id_valid"}, {31'd0, id_valid}, 32'd0);
    checkValue({tag, " rst id_inst"}, id_inst, NOP);
    checkValue({tag, " rst id_pc4"}, id_pc4, 32'd0);
    checkValue({tag, " rst stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
    checkValue({tag, " rst flush_cnt"}, {16'd0, flush_cnt}, 32'd0);
    checkValue({tag, " rst sat stall_cnt"}, {30'd0, s_stall}, 32'd0);
    checkValue({tag, " rst sat flush_cnt"}, {30'd0, s_flush}, 32'd0);
    checkValue({tag, " rst Hazard"}, {31'd0, Hazard}, 32'd0);
    checkValue({tag, " rst ex_bubble"}, {31'd0, ex_bubble}, 32'd1);
    @(posedge clk);
    #2;
    checkValue({tag, " rst held id_valid"}, {31'd0, id_valid}, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    Order = '0; FAOut = '0; Flag = 1'b0; Jump = 1'b0; ex_memread = 1'b1; ex_rd = 5'd17;

    //           order faout fl jp mr rd  hz bb inst pc4 v  st fl
    vecs[0]  = mk(I0,  4,  0, 0, 0, 0,  0, 1, I0,  4,  1, 0, 0);
    vecs[1]  = mk(IA,  8,  0, 0, 0, 0,  0, 0, IA,  8,  1, 0, 0);
    vecs[2]  = mk(IB,  12, 0, 0, 1, 5,  1, 1, IA,  8,  1, 1, 0);
    vecs[3]  = mk(IB,  12, 0, 0, 0, 0,  0, 0, IB,  12, 1, 1, 0);
    vecs[4]  = mk(IC,  16, 0, 0, 1, 0,  0, 0, IC,  16, 1, 1, 0);
    vecs[5]  = mk(ID,  20, 0, 0, 1, 2,  1, 1, IC,  16, 1, 2, 0);
    vecs[6]  = mk(ID,  20, 0, 0, 1, 3,  1, 1, IC,  16, 1, 3, 0);
    vecs[7]  = mk(ID,  20, 1, 0, 1, 3,  0, 0, NOP, 20, 0, 3, 1);
    vecs[8]  = mk(IE,  24, 0, 1, 0, 0,  0, 1, NOP, 24, 0, 3, 2);
    vecs[9]  = mk(IE,  28, 0, 1, 0, 0,  0, 1, NOP, 28, 0, 3, 3);
    vecs[10] = mk(IE,  32, 0, 1, 0, 0,  0, 1, NOP, 32, 0, 3, 4);
    vecs[11] = mk(ID,  36, 0, 0, 1, 7,  0, 1, ID,  36, 1, 3, 4);
    vecs[12] = mk(IE,  40, 0, 0, 1, 2,  1, 1, ID,  36, 1, 4, 4);
    vecs[13] = mk(IE,  40, 0, 0, 1, 17, 1, 1, ID,  36, 1, 5, 4);
    vecs[14] = mk(IE,  40, 0, 0, 0, 0,  0, 0, IE,  40, 1, 5, 4);
    vecs[15] = mk(IE,  44, 0, 0, 1, 13, 1, 1, IE,  40, 1, 6, 4);

    hand[0] = mk(I0, 4,  0, 0, 1, 17, 0, 1, I0,  4,  1, 0, 0);
    hand[1] = mk(IA, 8,  0, 1, 0, 0,  0, 0, NOP, 8,  0, 0, 1);
    hand[2] = mk(IA, 12, 0, 1, 0, 0,  0, 1, NOP, 12, 0, 0, 2);
    hand[3] = mk(IA, 16, 0, 1, 0, 0,  0, 1, NOP, 16, 0, 0, 3);
    hand[4] = mk(IA, 20, 0, 0, 0, 0,  0, 1, IA,  20, 1, 0, 0);

    resetPulse("init");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i], $sformatf("row%0d", i));
      checkOutput($sformatf("row%0d", i));
    end

    // Reset lands while the pipe sits in STALL with non-zero counters.
    resetPulse("midstall");
    applyStimulus(hand[0], "postreset");
    checkOutput("postreset");
    for (int i = 1; i < 4; i++) begin
      applyStimulus(hand[i], $sformatf("jump%0d", i));
      checkOutput($sformatf("jump%0d", i));
    end

    // Reset lands while the pipe sits in FLUSH.
    resetPulse("midflush");
    applyStimulus(hand[4], "resume");
    checkOutput("resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
